// File: rtl/skid_pipe_reg.sv
// Two-entry valid/ready pipeline register with a skid slot and stage-wide flush.
// in_ready and out_valid are pure decodes of the state register, so backpressure never crosses the stage combinationally.
module skid_pipe_reg #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  input  logic             flush,
  output logic [1:0]       occupancy
);

  // The encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_main;
  logic [WIDTH-1:0] r_skid;

  logic w_accept;
  logic w_drain;

  assign in_ready  = (r_state != FULL);
  assign out_valid = (r_state != EMPTY);
  assign out_data  = r_main;
  assign occupancy = r_state;

  assign w_accept = in_valid & in_ready;
  assign w_drain  = out_valid & out_ready;

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the data registers are reset too, so out_data is a defined 0 even while EMPTY.
      r_state <= EMPTY;
      r_main  <= '0;
      r_skid  <= '0;
    end else if (flush) begin
      r_state <= EMPTY;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_accept) begin
            r_state <= ONE;
            r_main  <= in_data;
          end
        end
        ONE: begin
          case ({w_accept, w_drain})
            2'b11: r_main <= in_data;
            2'b10: begin
              r_state <= FULL;
              r_skid  <= in_data;
            end
            2'b01:   r_state <= EMPTY;
            default: r_state <= ONE;
          endcase
        end
        FULL: begin
          // The skid word moves up into the output slot as the head drains.
          if (w_drain) begin
            r_state <= ONE;
            r_main  <= r_skid;
          end
        end
        default: r_state <= EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_skid_pipe_reg.sv
// Randomized and directed bench for skid_pipe_reg: a queue model tracks held words, a monitor pops and compares.
module tb_skid_pipe_reg;
  localparam int WIDTH = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;
  logic             flush;
  logic [1:0]       occupancy;

  skid_pipe_reg #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .flush     (flush),
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [WIDTH-1:0] exp_q[$];   // accepted words not yet delivered, oldest first
  int               model_cnt = 0;
  bit               mon_en    = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Applies the rules of the stage to what was driven during the cycle ending at this edge.
  task automatic model_edge();
    bit acc, drn;
    if (reset || flush) begin
      exp_q.delete();
      model_cnt = 0;
    end else begin
      acc = in_valid && (model_cnt < 2);
      drn = (model_cnt > 0) && out_ready;
      if (acc) exp_q.push_back(in_data);
      model_cnt = model_cnt + int'(acc) - int'(drn);
    end
  endtask

  task automatic step(input logic v, input logic [WIDTH-1:0] d, input logic ordy,
                      input logic fl, input logic rst);
    in_valid  = v;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    reset     = rst;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  // Monitor: mid-cycle checks of the handshake outputs and in-order delivery.
  bit               after_reset = 1'b0;
  bit               prev_hold   = 1'b0;
  logic [WIDTH-1:0] prev_data;
  always @(negedge clk) begin
    if (mon_en) begin
      check("out_valid", 32'(out_valid), 32'(model_cnt > 0));
      check("in_ready",  32'(in_ready),  32'(model_cnt < 2));
      check("occupancy", 32'(occupancy), 32'(model_cnt));
      if (after_reset) check("out_data_after_reset", 32'(out_data), 32'h0);
      if (prev_hold) check("out_data_stable", 32'(out_data), 32'(prev_data));
      if (out_valid && out_ready && !flush && !reset) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", 32'(out_data), 32'hFFFF_FFFF);
        end else begin
          check("out_data", 32'(out_data), 32'(exp_q.pop_front()));
        end
      end
      after_reset = reset;
      prev_hold   = out_valid && !out_ready && !flush && !reset;
      prev_data   = out_data;
    end
  end

  initial begin
    in_valid = 1'b1; in_data = 16'hAAAA; out_ready = 1'b0; flush = 1'b0; reset = 1'b1;

    // Reset held two cycles with a word offered.
    step(1'b1, 16'hAAAA, 1'b0, 1'b0, 1'b1);
    mon_en = 1'b1;
    step(1'b1, 16'hAAAA, 1'b0, 1'b0, 1'b1);
    step(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    step(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);

    // Streaming at full rate.
    for (int i = 1; i <= 8; i++) step(1'b1, WIDTH'(i), 1'b1, 1'b0, 1'b0);
    step(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    step(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);

    // Fill under backpressure, then drain.
    step(1'b1, 16'h0011, 1'b0, 1'b0, 1'b0);
    step(1'b1, 16'h0022, 1'b0, 1'b0, 1'b0);
    step(1'b1, 16'h0033, 1'b0, 1'b0, 1'b0);
    step(1'b1, 16'h0033, 1'b0, 1'b0, 1'b0);
    step(1'b1, 16'h0033, 1'b1, 1'b0, 1'b0);
    step(1'b1, 16'h0033, 1'b1, 1'b0, 1'b0);
    step(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    step(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);

    // Flush while full, with a word offered in the flush cycle.
    step(1'b1, 16'h0011, 1'b0, 1'b0, 1'b0);
    step(1'b1, 16'h0022, 1'b0, 1'b0, 1'b0);
    step(1'b1, 16'h0044, 1'b0, 1'b1, 1'b0);
    step(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    step(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);

    // Reset and flush together while full, then a fresh word.
    step(1'b1, 16'h0011, 1'b0, 1'b0, 1'b0);
    step(1'b1, 16'h0022, 1'b0, 1'b0, 1'b0);
    step(1'b0, 16'h0000, 1'b0, 1'b1, 1'b1);
    step(1'b1, 16'h0055, 1'b0, 1'b0, 1'b0);
    step(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    step(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);

    // Randomized traffic with occasional flush and reset.
    for (int i = 0; i < 3000; i++) begin
      step(1'($urandom_range(0, 3) != 0),
           WIDTH'($urandom),
           1'($urandom_range(0, 9) < 6),
           1'($urandom_range(0, 40) == 0),
           1'($urandom_range(0, 150) == 0));
    end

    for (int i = 0; i < 4; i++) step(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    check("queue_empty_at_end", 32'(exp_q.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
